// File: rtl/and_arb_pkg.sv
// Shared types, default sizing and the round-robin search used by the AND-unit arbiter.
package and_arb_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam int DEF_N     = 4;
  localparam int DEF_WIDTH = 8;
  localparam int MAX_N     = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] id;
  } pick_t;

  // First asserted request at or above ptr, wrapping at n; n never exceeds MAX_N.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req, input logic [2:0] ptr,
                                    input int n);
    pick_t p;
    int    idx;
    p = '0;
    for (int i = 0; i < MAX_N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !p.found && req[idx[2:0]]) begin
        p.found = 1'b1;
        p.id    = idx[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/and_unit_arbiter_and_reg_stage.sv
// Shared AND-and-register datapath; loads only when enabled.
module and_reg_stage
  import and_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else if (en_i) begin
      result_q <= operand_a_i & operand_b_i;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one registered AND stage among N requesters.
// Result is held with its requester ID until the consumer acknowledges it.
module and_unit_arbiter
  import and_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req_i,
  input  logic [N*WIDTH-1:0] a1_i,
  input  logic [N*WIDTH-1:0] a2_i,
  input  logic               ack_i,
  output logic [N-1:0]       gnt_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [IDW-1:0]     done_id_o,
  output logic [WIDTH-1:0]   result_o
);

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   grant_id_q;
  logic [IDW-1:0]   done_id_q;
  logic [N-1:0]     gnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;

  pick_t            pick_d;
  logic [IDW-1:0]   pick_id_d;
  logic [WIDTH-1:0] sel_a_d;
  logic [WIDTH-1:0] sel_b_d;
  logic             exec_en;

  always_comb begin
    pick_d    = rr_pick(MAX_N'(req_i), 3'(ptr_q), N);
    pick_id_d = IDW'(pick_d.id);
    sel_a_d   = '0;
    sel_b_d   = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_id_d == IDW'(i)) begin
        sel_a_d = a1_i[i*WIDTH +: WIDTH];
        sel_b_d = a2_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      done_id_q  <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_d.found) begin
            gnt_q[pick_id_d] <= 1'b1;
            grant_id_q       <= pick_id_d;
            op_a_q           <= sel_a_d;
            op_b_q           <= sel_b_d;
            busy_q           <= 1'b1;
            state_q          <= EXEC;
          end
        end
        EXEC: begin
          done_q    <= 1'b1;
          done_id_q <= grant_id_q;
          state_q   <= DONE;
        end
        DONE: begin
          // The pointer only moves once the result has actually been consumed.
          if (ack_i) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= (grant_id_q == IDW'(N-1)) ? '0 : grant_id_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign exec_en = (state_q == EXEC);

  and_reg_stage #(.WIDTH(WIDTH)) u_and_reg_stage (
    .clk         (clk),
    .reset       (reset),
    .en_i        (exec_en),
    .operand_a_i (op_a_q),
    .operand_b_i (op_b_q),
    .result_o    (result_o)
  );

  assign gnt_o     = gnt_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign done_id_o = done_id_q;

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Self-checking bench for and_unit_arbiter against a transaction-level round-robin model.
module tb_and_unit_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = $clog2(N);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N-1:0]       req = '0;
  logic [N*WIDTH-1:0] a1 = '0;
  logic [N*WIDTH-1:0] a2 = '0;
  logic               ack = 1'b0;
  logic [N-1:0]       gnt;
  logic               busy;
  logic               done;
  logic [IDW-1:0]     done_id;
  logic [WIDTH-1:0]   result;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  and_unit_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .a1_i      (a1),
    .a2_i      (a2),
    .ack_i     (ack),
    .gnt_o     (gnt),
    .busy_o    (busy),
    .done_o    (done),
    .done_id_o (done_id),
    .result_o  (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int id);
    logic [N-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] and_of(input int id);
    return a1[id*WIDTH +: WIDTH] & a2[id*WIDTH +: WIDTH];
  endfunction

  task automatic scramble_ops();
    for (int i = 0; i < N; i++) begin
      a1[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      a2[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    ack   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (gnt !== '0)    begin errors++; $display("FAIL reset_gnt got %b exp 0", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (done_id !== '0) begin errors++; $display("FAIL reset_done_id got %0d exp 0", done_id); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_single();
    a1[0 +: WIDTH] = 8'hF0;
    a2[0 +: WIDTH] = 8'h3C;
    ack = 1'b1;
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", gnt); end
    req = '0;
    tick();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL single_gnt_width got %b exp 0", gnt); end
    checks++; if (done !== 1'b1 || done_id !== 0 || result !== 8'h30)
      begin errors++; $display("FAIL single_result got done=%b id=%0d res=%h exp 1 0 30", done, done_id, result); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL single_clear got done=%b busy=%b exp 0 0", done, busy); end
    ack = 1'b0;
    m_ptr = 1;
  endtask

  task automatic test_round_robin();
    int               exp_id;
    logic [WIDTH-1:0] exp_res;
    do_reset();
    scramble_ops();
    req = '1;
    ack = 1'b1;
    for (int t = 0; t < 5; t++) begin
      exp_id  = model_pick(req, m_ptr);
      exp_res = and_of(exp_id);
      tick();
      checks++; if (gnt !== onehot(exp_id))
        begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", t, gnt, onehot(exp_id)); end
      if (t == 4) req = '0;
      scramble_ops();
      tick();
      checks++; if (done !== 1'b1 || done_id !== IDW'(exp_id) || result !== exp_res)
        begin errors++; $display("FAIL rr_result[%0d] got done=%b id=%0d res=%h exp 1 %0d %h", t, done, done_id, result, exp_id, exp_res); end
      tick();
      checks++; if (done !== 1'b0)
        begin errors++; $display("FAIL rr_clear[%0d] got done=%b exp 0", t, done); end
      m_ptr = (exp_id + 1) % N;
    end
    ack = 1'b0;
  endtask

  task automatic test_held();
    a1[2*WIDTH +: WIDTH] = 8'hAA;
    a2[2*WIDTH +: WIDTH] = 8'hFF;
    ack = 1'b0;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL held_gnt got %b exp 0100", gnt); end
    req = '0;
    tick();
    a1[2*WIDTH +: WIDTH] = 8'h00;
    for (int c = 0; c < 5; c++) begin
      checks++; if (done !== 1'b1 || done_id !== 2 || result !== 8'hAA)
        begin errors++; $display("FAIL held_stable[%0d] got done=%b id=%0d res=%h exp 1 2 aa", c, done, done_id, result); end
      tick();
    end
    ack = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL held_ack got done=%b busy=%b exp 0 0", done, busy); end
    ack = 1'b0;
    m_ptr = 3;
  endtask

  task automatic test_wrap();
    int exp_id;
    scramble_ops();
    ack = 1'b1;
    req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", gnt); end
    req = '0;
    tick();
    tick();
    m_ptr = 0;
    req = 4'b1001;
    for (int t = 0; t < 2; t++) begin
      exp_id = model_pick(req, m_ptr);
      tick();
      checks++; if (gnt !== onehot(exp_id))
        begin errors++; $display("FAIL wrap_gnt[%0d] got %b exp %b", t, gnt, onehot(exp_id)); end
      if (t == 1) req = '0;
      tick();
      checks++; if (done_id !== IDW'(exp_id) || result !== and_of(exp_id))
        begin errors++; $display("FAIL wrap_result[%0d] got id=%0d res=%h exp %0d %h", t, done_id, result, exp_id, and_of(exp_id)); end
      tick();
      m_ptr = (exp_id + 1) % N;
    end
    ack = 1'b0;
  endtask

  task automatic test_random();
    int               exp_id;
    int               hold;
    logic [WIDTH-1:0] exp_res;
    for (int t = 0; t < 25; t++) begin
      scramble_ops();
      req     = N'($urandom_range(1, (1 << N) - 1));
      ack     = 1'b0;
      exp_id  = model_pick(req, m_ptr);
      exp_res = and_of(exp_id);
      tick();
      checks++; if (gnt !== onehot(exp_id) || busy !== 1'b1)
        begin errors++; $display("FAIL rand_gnt[%0d] got gnt=%b busy=%b exp %b 1", t, gnt, busy, onehot(exp_id)); end
      req = N'($urandom);
      scramble_ops();
      tick();
      hold = $urandom_range(0, 3);
      for (int c = 0; c <= hold; c++) begin
        checks++; if (gnt !== '0 || done !== 1'b1 || done_id !== IDW'(exp_id) || result !== exp_res)
          begin errors++; $display("FAIL rand_done[%0d.%0d] got gnt=%b done=%b id=%0d res=%h exp 0 1 %0d %h", t, c, gnt, done, done_id, result, exp_id, exp_res); end
        if (c < hold) tick();
      end
      ack = 1'b1;
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0)
        begin errors++; $display("FAIL rand_clear[%0d] got done=%b busy=%b exp 0 0", t, done, busy); end
      ack = 1'b0;
      m_ptr = (exp_id + 1) % N;
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    scramble_ops();
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rmid_gnt got %b exp 0010", gnt); end
    reset = 1'b1;
    req   = 4'b0110;
    ack   = 1'b1;
    tick();
    checks++; if (gnt !== '0 || done !== 1'b0 || busy !== 1'b0 || result !== '0)
      begin errors++; $display("FAIL rmid_reset got gnt=%b done=%b busy=%b res=%h exp 0 0 0 0", gnt, done, busy, result); end
    reset = 1'b0;
    m_ptr = 0;
    tick();
    checks++; if (gnt !== onehot(model_pick(4'b0110, m_ptr)))
      begin errors++; $display("FAIL rmid_regrant got %b exp %b", gnt, onehot(model_pick(4'b0110, m_ptr))); end
    req = '0;
    tick();
    checks++; if (done_id !== 1 || result !== and_of(1))
      begin errors++; $display("FAIL rmid_result got id=%0d res=%h exp 1 %h", done_id, result, and_of(1)); end
    tick();
    ack = 1'b0;
    m_ptr = 2;
  endtask

  task automatic test_stray_ack();
    int exp_id;
    ack = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || gnt !== '0)
      begin errors++; $display("FAIL stray_idle got busy=%b done=%b gnt=%b exp 0 0 0", busy, done, gnt); end
    ack = 1'b0;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL stray_gnt got %b exp 0100", gnt); end
    req = '0;
    tick();
    tick();
    checks++; if (done !== 1'b1 || done_id !== 2 || result !== and_of(2))
      begin errors++; $display("FAIL stray_done got done=%b id=%0d res=%h exp 1 2 %h", done, done_id, result, and_of(2)); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    m_ptr = 3;
    req = '1;
    exp_id = model_pick(req, m_ptr);
    tick();
    checks++; if (gnt !== onehot(exp_id))
      begin errors++; $display("FAIL stray_ptr got %b exp %b", gnt, onehot(exp_id)); end
    req = '0;
    ack = 1'b1;
    tick();
    tick();
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_held();
    test_wrap();
    test_random();
    test_reset_mid();
    test_stray_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
